cpu_step_ctrl: RTL and testbench

Run/step/halt scheduler that sequences the CPU from the board's fast clock. It replaces a free-running divided clock with a one-cycle clock-enable pulse `cpu_en`, issued at a fixed divided rate in run mode or once per debounced pushbutton press in step mode. Pulses stop while the CPU reports halt. It sits between the board I/O (switch, button) and the CPU's clock-enable input, all in the `fastclk` domain.

---
 rtl/cpu_step_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// cpu_step_ctrl
// ----------------------------------------------------------------------------
// Run/step/halt scheduler for the CPU. It drives the CPU clock-enable with
// single-cycle pulses: one every 2^DIV_W fastclk cycles in run mode, or one
// per (optionally debounced) pushbutton press in step mode. Pulses stop while
// the CPU reports halt. Everything lives in the fastclk domain.
//
// Build option:
//   CPU_STEP_DEBOUNCE_EN  defined   -> pushbutton passes through a counter
//                                      based debounce filter (DB_W bits).
//                         undefined -> no filter and no DB_W parameter; the
//                                      synchronized button is used directly
//                                      (fast simulation build).
//
// Parameters:
//   DIV_W       free-run enable period is 2^DIV_W fastclk cycles
//   DB_W        button must differ from the filtered value for 2^DB_W
//               consecutive cycles before the filter follows it
//               (only present with CPU_STEP_DEBOUNCE_EN)
//
// Ports:
//   fastclk     in   1   sole clock, rising edge
//   n_reset     in   1   asynchronous active-low reset
//   run         in   1   raw slide switch (async): 1 = run, 0 = step
//   step_btn    in   1   raw pushbutton (async), active-high
//   halt        in   1   CPU halted flag, already synchronous to fastclk
//   cpu_en      out  1   registered one-cycle clock-enable pulse
//   step_count  out 16   number of cpu_en pulses issued, wraps
//   state       out  2   STEP=2'b00, RUN=2'b01, HALT=2'b10
// ============================================================================
module cpu_step_ctrl #(
    parameter int unsigned DIV_W = 25
`ifdef CPU_STEP_DEBOUNCE_EN
    ,
    parameter int unsigned DB_W  = 20
`endif
) (
    input  logic        fastclk,
    input  logic        n_reset,
    input  logic        run,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_en,
    output logic [15:0] step_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_STEP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers (run switch and pushbutton are asynchronous)
    // ------------------------------------------------------------------
    logic run_meta_q;
    logic run_s_q;
    logic btn_meta_q;
    logic btn_s_q;

    // Two-flop synchronizers for the raw board inputs.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
        end else begin
            run_meta_q <= run;
            run_s_q    <= run_meta_q;
            btn_meta_q <= step_btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Button conditioning: filtered level db_s
    // ------------------------------------------------------------------
    logic db_s;

`ifdef CPU_STEP_DEBOUNCE_EN
    logic            db_filt_q;
    logic            db_filt_d;
    logic [DB_W-1:0] dbc_q;
    logic [DB_W-1:0] dbc_d;

    // Debounce next-state: the filter only follows the button after it has
    // disagreed for 2^DB_W consecutive cycles; any agreement restarts the
    // count, so bounces shorter than that never reach db.
    always_comb begin
        db_filt_d = db_filt_q;
        dbc_d     = dbc_q;
        if (btn_s_q == db_filt_q) begin
            dbc_d = '0;
        end else if (&dbc_q) begin
            db_filt_d = btn_s_q;
            dbc_d     = '0;
        end else begin
            dbc_d = dbc_q + DB_W'(1);
        end
    end

    // Debounce filter registers.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            db_filt_q <= 1'b0;
            dbc_q     <= '0;
        end else begin
            db_filt_q <= db_filt_d;
            dbc_q     <= dbc_d;
        end
    end

    assign db_s = db_filt_q;
`else
    assign db_s = btn_s_q;
`endif

    // ------------------------------------------------------------------
    // Rising-edge detect on the filtered button
    // ------------------------------------------------------------------
    logic db_dly_q;
    logic btn_rise_s;

    // One-cycle delayed copy of the filtered button level.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            db_dly_q <= 1'b0;
        end else begin
            db_dly_q <= db_s;
        end
    end

    assign btn_rise_s = db_s & ~db_dly_q;

    // ------------------------------------------------------------------
    // Scheduler FSM, divider, enable pulse and pulse counter
    // ------------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic [15:0]      step_count_q;
    logic [15:0]      step_count_d;

    // Next mode: halt dominates, then the synchronized run switch. HALT is
    // left as soon as halt drops and the switch picks the new mode.
    always_comb begin
        if (halt) begin
            state_d = ST_HALT;
        end else if (run_s_q) begin
            state_d = ST_RUN;
        end else begin
            state_d = ST_STEP;
        end
    end

    // Divider counts only while staying in RUN; any other cycle clears it so
    // each entry into RUN waits a full period before the first pulse.
    always_comb begin
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
        end
    end

    // Enable pulse: the mode must be stable across this edge (same mode now
    // and next), so a press or divider wrap coinciding with a mode change or
    // halt rising is dropped rather than queued.
    always_comb begin
        case (state_q)
            ST_RUN:  cpu_en_d = ~halt & run_s_q & (&div_q);
            ST_STEP: cpu_en_d = ~halt & ~run_s_q & btn_rise_s;
            ST_HALT: cpu_en_d = 1'b0;
            default: cpu_en_d = 1'b0;
        endcase
    end

    // Pulse counter advances once per issued enable pulse, wrapping at 16 bits.
    always_comb begin
        if (cpu_en_q) begin
            step_count_d = step_count_q + 16'd1;
        end else begin
            step_count_d = step_count_q;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge fastclk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_STEP;
            div_q        <= '0;
            cpu_en_q     <= 1'b0;
            step_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// tb_cpu_step_ctrl
// ----------------------------------------------------------------------------
// Directed bench for cpu_step_ctrl with DIV_W=3 (period 8) and, when
// CPU_STEP_DEBOUNCE_EN is defined, DB_W=2. Expected step-mode latencies are
// chosen from the same macro: pulse after edge 7 with the filter, after
// edge 3 without it.
// ============================================================================
module tb_cpu_step_ctrl;

`ifdef CPU_STEP_DEBOUNCE_EN
    localparam int PE         = 7;
    localparam bit DB_ON      = 1'b1;
    localparam int BOUNCE_EXP = 0;
`else
    localparam int PE         = 3;
    localparam bit DB_ON      = 1'b0;
    localparam int BOUNCE_EXP = 5;
`endif

    logic        fastclk = 1'b0;
    logic        n_reset;
    logic        run;
    logic        step_btn;
    logic        halt;
    logic        cpu_en;
    logic [15:0] step_count;
    logic [1:0]  state;

    int n_checks  = 0;
    int n_pass    = 0;
    int exp_count = 0;
    int pulses    = 0;

    cpu_step_ctrl #(
        .DIV_W(3)
`ifdef CPU_STEP_DEBOUNCE_EN
        ,
        .DB_W(2)
`endif
    ) dut (
        .fastclk    (fastclk),
        .n_reset    (n_reset),
        .run        (run),
        .step_btn   (step_btn),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .step_count (step_count),
        .state      (state)
    );

    // 10-unit clock period.
    always #5 fastclk = ~fastclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge fastclk);
        #1;
    endtask

    initial begin
        n_reset  = 1'b1;
        run      = 1'b1;
        step_btn = 1'b0;
        halt     = 1'b0;
        #1;
        n_reset  = 1'b0;
        #1;
        check_val("rst_en",    {31'd0, cpu_en}, 32'd0);
        check_val("rst_cnt",   {16'd0, step_count}, 32'd0);
        check_val("rst_state", {30'd0, state}, 32'd0);
        n_reset = 1'b1;

        // Free run: RUN reached at edge 3, pulses at edges 11, 19, 27, 35.
        tick();
        tick();
        check_val("pre_run_state", {30'd0, state}, 32'd0);
        tick();
        check_val("run_state", {30'd0, state}, 32'd1);
        for (int e = 4; e <= 36; e++) begin
            tick();
            check_val("run_en", {31'd0, cpu_en}, (e % 8 == 3) ? 32'd1 : 32'd0);
        end
        exp_count = 4;
        check_val("run_cnt", {16'd0, step_count}, exp_count);

        // Halt during RUN: HALT next edge, silent for 50 cycles.
        halt = 1'b1;
        tick();
        check_val("halt_state", {30'd0, state}, 32'd2);
        check_val("halt_en0", {31'd0, cpu_en}, 32'd0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check_val("halt_en", {31'd0, cpu_en}, 32'd0);
        end
        check_val("halt_state_hold", {30'd0, state}, 32'd2);

        // Release halt: RUN next edge, first pulse 8 edges later.
        halt = 1'b0;
        tick();
        check_val("resume_state", {30'd0, state}, 32'd1);
        for (int j = 1; j <= 15; j++) begin
            tick();
            check_val("resume_en", {31'd0, cpu_en}, (j == 8) ? 32'd1 : 32'd0);
        end
        exp_count++;

        // Halt rising on the edge that would have pulsed blocks that pulse.
        halt = 1'b1;
        tick();
        check_val("blk_en", {31'd0, cpu_en}, 32'd0);
        check_val("blk_state", {30'd0, state}, 32'd2);
        check_val("blk_cnt", {16'd0, step_count}, exp_count);

        // Button pressed while halted is dropped.
        run      = 1'b0;
        step_btn = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) step_btn = 1'b0;
            tick();
            check_val("halt_btn_en", {31'd0, cpu_en}, 32'd0);
        end
        check_val("halt_btn_state", {30'd0, state}, 32'd2);
        halt = 1'b0;
        tick();
        check_val("step_state", {30'd0, state}, 32'd0);
        for (int i = 0; i < 3; i++) tick();

        // Single step: 10 cycles high then 10 low, exactly one pulse.
        step_btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            if (e == 11) step_btn = 1'b0;
            tick();
            check_val("step_en", {31'd0, cpu_en}, (e == PE) ? 32'd1 : 32'd0);
        end
        exp_count++;
        check_val("step_cnt", {16'd0, step_count}, exp_count);
        for (int i = 0; i < 4; i++) tick();

        // Bounce: toggle every 2 cycles for 20 cycles, then low.
        pulses = 0;
        for (int e = 1; e <= 30; e++) begin
            step_btn = (e <= 20 && ((e - 1) / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (cpu_en) pulses++;
        end
        check_val("bounce_pulses", pulses, BOUNCE_EXP);
        exp_count += BOUNCE_EXP;
        check_val("bounce_cnt", {16'd0, step_count}, exp_count);

        // One-cycle press: pulses after edge 3 only without the filter.
        step_btn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 1) step_btn = 1'b0;
            check_val("short_en", {31'd0, cpu_en}, (!DB_ON && e == 3) ? 32'd1 : 32'd0);
        end
        if (!DB_ON) exp_count++;
        check_val("short_cnt", {16'd0, step_count}, exp_count);
        for (int i = 0; i < 4; i++) tick();

        // Asynchronous reset in the middle of a pulse clears outputs at once.
        step_btn = 1'b1;
        for (int e = 1; e <= PE; e++) tick();
        check_val("pre_rst_en", {31'd0, cpu_en}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check_val("arst_en",    {31'd0, cpu_en}, 32'd0);
        check_val("arst_cnt",   {16'd0, step_count}, 32'd0);
        check_val("arst_state", {30'd0, state}, 32'd0);
        step_btn = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("post_rst_en",  {31'd0, cpu_en}, 32'd0);
        check_val("post_rst_cnt", {16'd0, step_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
